// File: rtl/wb_ram_slave.sv
// Wishbone classic-cycle slave in front of a word-addressed RAM with byte-lane writes and programmable wait states.
// Optional address range check (err response) enabled by defining WB_RAM_SLAVE_ADDR_CHECK_EN.
module wb_ram_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            enter_resp;

  logic            we_q;
  logic [3:0]      sel_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     dat_q;
  logic            bad_q;

  logic            req;
  logic [31:0]     offset;
  logic [AW-1:0]   req_idx;
  logic            req_bad;

  logic            acc_we;
  logic [3:0]      acc_sel;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_dat;
  logic            acc_bad;

  logic [31:0]     mem [DEPTH];
  logic            ack_q;

  assign req     = wb_cyc_i & wb_stb_i;
  assign offset  = wb_adr_i - BASE_ADDR;
  assign req_idx = offset[AW+1:2];

  // Byte-offset bits and the aliased upper bits do not take part in indexing.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[1:0], offset[31:AW+2]};

`ifdef WB_RAM_SLAVE_ADDR_CHECK_EN
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
  assign req_bad = ({1'b0, offset} >= SPAN);
`else
  assign req_bad = 1'b0;
`endif

  // With zero wait states the access happens on the sampling edge itself,
  // so the live bus is used; otherwise the latched request is used.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we  = wb_we_i;
      acc_sel = wb_sel_i;
      acc_idx = req_idx;
      acc_dat = wb_dat_i;
      acc_bad = req_bad;
    end else begin
      acc_we  = we_q;
      acc_sel = sel_q;
      acc_idx = idx_q;
      acc_dat = dat_q;
      acc_bad = bad_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      idx_q    <= '0;
      dat_q    <= 32'd0;
      bad_q    <= 1'b0;
      ack_q    <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req) begin
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
        idx_q <= req_idx;
        dat_q <= wb_dat_i;
        bad_q <= req_bad;
      end
      ack_q <= enter_resp & ~acc_bad;
      // Read data is only driven for the acked cycle; zero otherwise.
      if (enter_resp && !acc_we && !acc_bad) begin
        wb_dat_o <= mem[acc_idx];
      end else begin
        wb_dat_o <= 32'd0;
      end
    end
  end

`ifdef WB_RAM_SLAVE_ADDR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= enter_resp & acc_bad;
    end
  end
  assign wb_err_o = err_q;
`else
  assign wb_err_o = 1'b0;
`endif

  // RAM array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (rstn_i && enter_resp && acc_we && !acc_bad) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
        end
      end
    end
  end

  assign wb_ack_o  = ack_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: one instance with 0 wait states and one with 3, sharing a bus selected by tgt.
// Read expectations go through a scoreboard queue; range-check expectations follow WB_RAM_SLAVE_ADDR_CHECK_EN.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cyc, stb, we, tgt;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;

  logic [31:0] dat0, dat3;
  logic        ack0, ack3, err0, err3;
  logic [1:0]  st0, st3;
  logic        ack, err;
  logic [31:0] dat;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wb_ram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rstn_i(rstn),
    .wb_cyc_i(cyc & ~tgt), .wb_stb_i(stb & ~tgt), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .dbg_state(st0)
  );

  wb_ram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rstn_i(rstn),
    .wb_cyc_i(cyc & tgt), .wb_stb_i(stb & tgt), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3), .dbg_state(st3)
  );

  assign ack = tgt ? ack3 : ack0;
  assign err = tgt ? err3 : err0;
  assign dat = tgt ? dat3 : dat0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One transfer; bus inputs are scrambled after the sampling edge to prove they were latched.
  task automatic xfer(input string tag, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, input int exp_lat, input logic exp_err);
    logic        got;
    int          lat;
    logic        oa, oe;
    logic [31:0] rd;
    got = 1'b0; lat = 0; oa = 1'b0; oe = 1'b0; rd = 32'd0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        got = 1'b1; lat = n + 1; oa = ack; oe = err; rd = dat;
        cyc = 1'b0; stb = 1'b0;
      end else begin
        check({tag, "_dat_idle"}, dat, 32'd0);
        sel  = 4'($urandom_range(0, 15));
        adr  = $urandom_range(0, 32'hFFFF);
        wdat = $urandom;
        we   = ~w;
      end
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    cyc = 1'b0; stb = 1'b0;
    if (got) begin
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_ack"}, 32'(oa), 32'(!exp_err));
      check({tag, "_err"}, 32'(oe), 32'(exp_err));
      if (exp_err || w) begin
        check({tag, "_dat_zero"}, rd, 32'd0);
      end else if (exp_q.size() > 0) begin
        check({tag, "_rdata"}, rd, exp_q.pop_front());
      end else begin
        check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end
      @(posedge clk); #1;
      check({tag, "_ack_pulse"}, 32'(ack | err), 32'd0);
    end
  endtask

  initial begin
    int acks;
    logic [31:0] held_adr [3];
    rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; tgt = 1'b0;
    sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_dat0", dat0, 32'd0);
    check("rst_st0", 32'(st0), 32'd0);
    check("rst_st3", 32'(st3), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Zero wait states: basic write/read, ignored low address bits
    xfer("w_10", 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    xfer("r_10", 1'b0, 4'hF, 32'h10, 32'h0, 1, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    xfer("r_13", 1'b0, 4'h0, 32'h13, 32'h0, 1, 1'b0);

    // Byte lanes and sel=0 write
    xfer("w_20_pre", 1'b1, 4'hF, 32'h20, 32'h1122_3344, 1, 1'b0);
    xfer("w_20_lane", 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 1, 1'b0);
    exp_q.push_back(32'h11BB_33DD);
    xfer("r_20_lane", 1'b0, 4'h1, 32'h20, 32'h0, 1, 1'b0);
    xfer("w_20_sel0", 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF, 1, 1'b0);
    exp_q.push_back(32'h11BB_33DD);
    xfer("r_20_sel0", 1'b0, 4'hF, 32'h20, 32'h0, 1, 1'b0);

    // Three wait states: preload, then three reads with stb held
    tgt = 1'b1;
    xfer("w3_40", 1'b1, 4'hF, 32'h40, 32'hA0A0_0001, 4, 1'b0);
    xfer("w3_44", 1'b1, 4'hF, 32'h44, 32'hB0B0_0002, 4, 1'b0);
    xfer("w3_48", 1'b1, 4'hF, 32'h48, 32'hC0C0_0003, 4, 1'b0);
    held_adr[0] = 32'h40; held_adr[1] = 32'h44; held_adr[2] = 32'h48;
    exp_q.push_back(32'hA0A0_0001);
    exp_q.push_back(32'hB0B0_0002);
    exp_q.push_back(32'hC0C0_0003);
    acks = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = held_adr[0];
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (ack) begin
        acks++;
        check("held_ack_cycle", 32'(n + 1), 32'(4 + 5 * (acks - 1)));
        if (exp_q.size() > 0) check("held_rdata", dat, exp_q.pop_front());
        else check("held_sb_empty", 32'd1, 32'd0);
        if (acks < 3) adr = held_adr[acks];
        else begin cyc = 1'b0; stb = 1'b0; end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    check("held_ack_count", 32'(acks), 32'd3);

    // Abort: drop cyc while in WAIT during a write
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h40; wdat = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      check("abort_no_ack", 32'(ack | err), 32'd0);
    end
    exp_q.push_back(32'hA0A0_0001);
    xfer("r3_40_abort", 1'b0, 4'hF, 32'h40, 32'h0, 4, 1'b0);

    // Reset in WAIT during a write
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h48; wdat = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("rst_wait_ack", 32'(ack3), 32'd0);
    check("rst_wait_err", 32'(err3), 32'd0);
    check("rst_wait_dat", dat3, 32'd0);
    check("rst_wait_state", 32'(st3), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.push_back(32'hC0C0_0003);
    xfer("r3_48_rst", 1'b0, 4'hF, 32'h48, 32'h0, 4, 1'b0);

    // Out-of-range write on the zero-wait instance
    tgt = 1'b0;
    xfer("w_00", 1'b1, 4'hF, 32'h0, 32'h0102_0304, 1, 1'b0);
`ifdef WB_RAM_SLAVE_ADDR_CHECK_EN
    xfer("w_1000_err", 1'b1, 4'hF, 32'h1000, 32'h55AA_55AA, 1, 1'b1);
    exp_q.push_back(32'h0102_0304);
`else
    xfer("w_1000_alias", 1'b1, 4'hF, 32'h1000, 32'h55AA_55AA, 1, 1'b0);
    exp_q.push_back(32'h55AA_55AA);
`endif
    xfer("r_00_range", 1'b0, 4'hF, 32'h0, 32'h0, 1, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
